nios2_oci_pib_ser: RTL and testbench
====================================

NIOS2_OCI_PIB_SER -- requirements
Module: nios2_oci_pib_ser

Interface
REQ-001 SHALL have parameter TW_WIDTH, default 36: trace word width.
REQ-002 SHALL have parameter OUT_WIDTH, default 18: trace pin width; TW_WIDTH SHALL be an integer multiple of it, and SLICES = TW_WIDTH/OUT_WIDTH SHALL be >= 2.
REQ-003 SHALL have parameter DEPTH, default 4: FIFO entries, power of 2, >= 2.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 jrst_n  in  1  asynchronous active-low reset.
REQ-006 tw_valid  in  1  trace word present this cycle.
REQ-007 tw  in  TW_WIDTH  trace word.
REQ-008 tr_enable  in  1  permits the serializer to start new words.
REQ-009 ovf_clr  in  1  single-cycle clear of the overflow counter.
REQ-010 tr_clk  out  1  toggles once per emitted slice.
REQ-011 tr_data  out  OUT_WIDTH  current slice, registered.
REQ-012 tr_active  out  1  high while a slice is being driven.
REQ-013 fifo_full  out  1  FIFO holds DEPTH words.
REQ-014 ovf_count  out  8  dropped-word count, saturating.

Function
REQ-015 The block SHALL NOT apply backpressure: a word with tw_valid=1 SHALL be written to the FIFO when not full, or when full with a pop in the same cycle.
REQ-016 A word with tw_valid=1 arriving while full without a same-cycle pop SHALL be dropped, and ovf_count SHALL increment, saturating at 255.
REQ-017 ovf_clr=1 SHALL set ovf_count to 0; if a drop occurs in the same cycle, ovf_count SHALL become 1.
REQ-018 Serializer FSM states: IDLE, SHIFT.
REQ-019 IDLE->SHIFT: FIFO non-empty and tr_enable=1; pop the head word into the shift register; slice index = 0.
REQ-020 In SHIFT, each cycle SHALL register one slice to tr_data, most-significant slice first (default: tw[35:18], then tw[17:0]), toggle tr_clk, and set tr_active=1.
REQ-021 On the last slice (index SLICES-1): if FIFO non-empty and tr_enable=1, the next word SHALL be popped and SHIFT continues with no gap; otherwise -> IDLE.
REQ-022 Deasserting tr_enable mid-word SHALL NOT truncate the word; the current word completes, then the FSM enters IDLE.
REQ-023 In IDLE, tr_data SHALL be 0, tr_active 0, and tr_clk SHALL hold its last value.
REQ-024 Latency: with the FIFO empty, a word accepted at edge N SHALL present its first slice on tr_data after edge N+2.
REQ-025 Sustained throughput SHALL be one word per SLICES cycles; FIFO pointers SHALL wrap modulo DEPTH, and the count SHALL be held in clog2(DEPTH)+1 bits.
REQ-026 fifo_full SHALL be registered-state derived (count==DEPTH), with no combinational path from tw_valid.

Reset
REQ-027 jrst_n=0 SHALL asynchronously clear all of the following, including mid-word: FSM to IDLE, FIFO pointers/count, shift register, slice index, tr_clk=0, tr_data=0, tr_active=0, fifo_full=0, ovf_count=0.
REQ-028 FIFO storage array SHALL NOT require reset; content is irrelevant while empty.

Structure
REQ-029 Package nios2_oci_pib_pkg SHALL hold the FSM state enum and the ovf_count width constant (8).
REQ-030 FIFO SHALL be a sub-module nios2_oci_pib_fifo (params WIDTH, DEPTH; push, pop, dout, empty, full); the serializer FSM, overflow counter and output registers reside in the top module.

Verification
REQ-031 Single word, defaults: tw=36'h9_ABCD_1234, tr_enable=1 -> 2 and 3 cycles later tr_data=18'h26AF3 then 18'h11234; tr_clk toggles twice; then tr_data=0, tr_active=0.
REQ-032 Back-to-back: 4 consecutive words A,B,C,D -> 8 contiguous slices, tr_active high 8 cycles, ovf_count=0.
REQ-033 Overflow: tr_enable=0, 6 words pushed -> fifo_full=1 after word 4, ovf_count=2; enable -> exactly words 1-4 emitted in order.
REQ-034 Saturation/clear: 300 drops -> ovf_count=255; ovf_clr concurrent with a drop -> ovf_count=1.
REQ-035 Full with same-cycle pop and push -> no drop, word order preserved; tr_enable dropped mid-word -> second slice still emitted.
REQ-036 jrst_n pulsed low during the first slice -> all outputs 0 immediately; first post-reset push emits cleanly with ovf_count=0.

Source files
------------

// File: rtl/nios2_oci_pib_pkg.sv
// Shared types and constants for the OCI trace pin serializer.
package nios2_oci_pib_pkg;

  localparam int unsigned OVF_W = 8;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_e;

endpackage

// File: rtl/nios2_oci_pib_fifo.sv
// Trace word FIFO: fall-through read, registered flags, storage left unreset.
module nios2_oci_pib_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             jrst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;
  logic             do_push_c;
  logic             do_pop_c;

  // A push into a full FIFO is legal only when a pop frees the slot in the same cycle.
  assign do_pop_c  = pop && !empty;
  assign do_push_c = push && (!full || do_pop_c);
  assign dout      = mem[rd_ptr];

  // Occupancy update.
  always_comb begin
    count_nxt = count;
    case ({do_push_c, do_pop_c})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and flags; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      if (do_push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      empty <= (count_nxt == '0);
      full  <= (count_nxt == CNT_W'(DEPTH));
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push_c) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/nios2_oci_pib_ser.sv
// Trace pin serializer: buffers trace words and emits them MS slice first on tr_data.
module nios2_oci_pib_ser
  import nios2_oci_pib_pkg::*;
#(
  parameter int unsigned TW_WIDTH  = 36,
  parameter int unsigned OUT_WIDTH = 18,
  parameter int unsigned DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 jrst_n,
  input  logic                 tw_valid,
  input  logic [TW_WIDTH-1:0]  tw,
  input  logic                 tr_enable,
  input  logic                 ovf_clr,
  output logic                 tr_clk,
  output logic [OUT_WIDTH-1:0] tr_data,
  output logic                 tr_active,
  output logic                 fifo_full,
  output logic [OVF_W-1:0]     ovf_count
);

  localparam int unsigned SLICES = TW_WIDTH / OUT_WIDTH;
  localparam int unsigned IDX_W  = $clog2(SLICES);

  ser_state_e           state;
  ser_state_e           state_nxt;
  logic [TW_WIDTH-1:0]  shreg;
  logic [TW_WIDTH-1:0]  shreg_nxt;
  logic [IDX_W-1:0]     idx;
  logic [IDX_W-1:0]     idx_nxt;
  logic [OUT_WIDTH-1:0] tr_data_nxt;
  logic                 tr_active_nxt;
  logic                 tr_clk_nxt;
  logic [OVF_W-1:0]     ovf_nxt;
  logic [TW_WIDTH-1:0]  fifo_dout;
  logic                 fifo_empty;
  logic                 take_c;
  logic                 last_c;
  logic                 pop_c;
  logic                 push_c;
  logic                 drop_c;

  assign take_c = tr_enable && !fifo_empty;
  assign last_c = (idx == IDX_W'(SLICES - 1));
  assign push_c = tw_valid && (!fifo_full || pop_c);
  assign drop_c = tw_valid && fifo_full && !pop_c;

  nios2_oci_pib_fifo #(
    .WIDTH (TW_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .jrst_n (jrst_n),
    .push   (push_c),
    .pop    (pop_c),
    .din    (tw),
    .dout   (fifo_dout),
    .empty  (fifo_empty),
    .full   (fifo_full)
  );

  // Serializer next state: load on start or after the last slice, otherwise shift out.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    idx_nxt       = idx;
    tr_data_nxt   = '0;
    tr_active_nxt = 1'b0;
    tr_clk_nxt    = tr_clk;
    pop_c         = 1'b0;
    case (state)
      IDLE: begin
        if (take_c) begin
          pop_c     = 1'b1;
          shreg_nxt = fifo_dout;
          idx_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        tr_data_nxt   = shreg[TW_WIDTH-1 -: OUT_WIDTH];
        tr_active_nxt = 1'b1;
        tr_clk_nxt    = ~tr_clk;
        if (last_c) begin
          idx_nxt = '0;
          if (take_c) begin
            pop_c     = 1'b1;
            shreg_nxt = fifo_dout;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          idx_nxt   = idx + IDX_W'(1);
          shreg_nxt = shreg << OUT_WIDTH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating drop counter; a clear wins but still counts a same-cycle drop.
  always_comb begin
    ovf_nxt = ovf_count;
    if (ovf_clr) begin
      ovf_nxt = drop_c ? OVF_W'(1) : '0;
    end else if (drop_c && (ovf_count != OVF_MAX)) begin
      ovf_nxt = ovf_count + OVF_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge jrst_n) begin
    if (!jrst_n) begin
      shreg     <= '0;
      idx       <= '0;
      tr_data   <= '0;
      tr_active <= 1'b0;
      tr_clk    <= 1'b0;
      ovf_count <= '0;
    end else begin
      shreg     <= shreg_nxt;
      idx       <= idx_nxt;
      tr_data   <= tr_data_nxt;
      tr_active <= tr_active_nxt;
      tr_clk    <= tr_clk_nxt;
      ovf_count <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_nios2_oci_pib_ser.sv
// Bench for nios2_oci_pib_ser: hand vectors, directed corner cases, random vs queue model.
module tb_nios2_oci_pib_ser;

  localparam int unsigned TW     = 36;
  localparam int unsigned OW     = 18;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned SLICES = TW / OW;

  logic          clk;
  logic          jrst_n;
  logic          tw_valid;
  logic [TW-1:0] tw;
  logic          tr_enable;
  logic          ovf_clr;
  logic          tr_clk;
  logic [OW-1:0] tr_data;
  logic          tr_active;
  logic          fifo_full;
  logic [7:0]    ovf_count;

  int checks = 0;
  int errors = 0;

  nios2_oci_pib_ser #(
    .TW_WIDTH  (TW),
    .OUT_WIDTH (OW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .jrst_n    (jrst_n),
    .tw_valid  (tw_valid),
    .tw        (tw),
    .tr_enable (tr_enable),
    .ovf_clr   (ovf_clr),
    .tr_clk    (tr_clk),
    .tr_data   (tr_data),
    .tr_active (tr_active),
    .fifo_full (fifo_full),
    .ovf_count (ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a bounded word queue plus the word currently on the pins.
  logic [TW-1:0] mq[$];
  bit            m_busy;
  logic [TW-1:0] m_cur;
  int            m_sl;
  logic [OW-1:0] m_data;
  bit            m_act;
  bit            m_clk;
  int            m_ovf;

  function automatic void model_reset();
    mq.delete();
    m_busy = 0; m_cur = '0; m_sl = 0;
    m_data = '0; m_act = 0; m_clk = 0; m_ovf = 0;
  endfunction

  function automatic void model_edge(input bit v, input logic [TW-1:0] w, input bit en, input bit clr);
    bit was_full;
    bit take;
    bit drop;
    logic [TW-1:0] tmp;
    was_full = (mq.size() == DEPTH);
    // A new word may be taken when nothing is on the pins or the last slice is going out now.
    take = en && (mq.size() > 0) && (!m_busy || m_sl == SLICES - 1);
    if (m_busy) begin
      tmp    = m_cur >> ((SLICES - 1 - m_sl) * OW);
      m_data = tmp[OW-1:0];
      m_act  = 1;
      m_clk  = !m_clk;
      m_sl++;
      if (m_sl == SLICES) m_busy = 0;
    end else begin
      m_data = '0;
      m_act  = 0;
    end
    if (take) begin
      m_cur  = mq.pop_front();
      m_busy = 1;
      m_sl   = 0;
    end
    drop = v && was_full && !take;
    if (v && !drop) mq.push_back(w);
    if (clr)                     m_ovf = drop ? 1 : 0;
    else if (drop && m_ovf < 255) m_ovf++;
  endfunction

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void compare_model();
    chk("model tr_data",   64'(tr_data),   64'(m_data));
    chk("model tr_active", 64'(tr_active), 64'(m_act));
    chk("model tr_clk",    64'(tr_clk),    64'(m_clk));
    chk("model fifo_full", 64'(fifo_full), 64'(mq.size() == DEPTH));
    chk("model ovf_count", 64'(ovf_count), 64'(m_ovf));
  endfunction

  task automatic step(input bit v, input logic [TW-1:0] w, input bit en, input bit clr);
    tw_valid = v; tw = w; tr_enable = en; ovf_clr = clr;
    @(posedge clk);
    model_edge(v, w, en, clr);
    #1;
    compare_model();
  endtask

  task automatic do_reset();
    tw_valid = 0; tw = '0; tr_enable = 0; ovf_clr = 0;
    jrst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    compare_model();
    jrst_n = 1;
  endtask

  function automatic logic [TW-1:0] wk(input int k);
    return {18'(32'h0A00 + k), 18'(32'h0B00 + k)};
  endfunction

  typedef struct {
    bit            rst;
    bit            vld;
    logic [TW-1:0] w;
    bit            en;
    bit            clr;
    logic [OW-1:0] e_data;
    bit            e_act;
    bit            e_clk;
    bit            e_full;
    logic [7:0]    e_ovf;
  } vec_t;

  vec_t vt[$];

  function automatic void add(input bit rst, input bit vld, input logic [TW-1:0] w, input bit en,
                              input bit clr, input logic [OW-1:0] d, input bit a, input bit c,
                              input bit f, input logic [7:0] o);
    vec_t r;
    r.rst = rst; r.vld = vld; r.w = w; r.en = en; r.clr = clr;
    r.e_data = d; r.e_act = a; r.e_clk = c; r.e_full = f; r.e_ovf = o;
    vt.push_back(r);
  endfunction

  logic [OW-1:0] got[$];
  logic [OW-1:0] exp_sl[$];
  int first_act;
  int last_act;
  int n_act;

  initial begin
    jrst_n = 0; tw_valid = 0; tw = '0; tr_enable = 0; ovf_clr = 0;
    model_reset();

    // Single word: first slice two edges after acceptance.
    add(1, 1, 36'h9_ABCD_1234, 1, 0, 18'h0,     0, 0, 0, 0);
    add(0, 0, '0,              1, 0, 18'h0,     0, 0, 0, 0);
    add(0, 0, '0,              1, 0, 18'h26AF3, 1, 1, 0, 0);
    add(0, 0, '0,              1, 0, 18'h11234, 1, 0, 0, 0);
    add(0, 0, '0,              1, 0, 18'h0,     0, 0, 0, 0);
    add(0, 0, '0,              1, 0, 18'h0,     0, 0, 0, 0);
    // Overflow: six pushes while disabled, then drain the first four.
    for (int k = 0; k < 6; k++)
      add(k == 0, 1, wk(k + 1), 0, 0, 18'h0, 0, 0, k >= 3, 8'((k >= 4) ? k - 3 : 0));
    add(0, 0, '0, 1, 0, 18'h0, 0, 0, 0, 8'd2);
    for (int j = 0; j < 8; j++)
      add(0, 0, '0, 1, 0, (j % 2 == 0) ? 18'(32'h0A00 + j / 2 + 1) : 18'(32'h0B00 + j / 2 + 1),
          1, j % 2 == 0, 0, 8'd2);
    add(0, 0, '0, 1, 0, 18'h0, 0, 0, 0, 8'd2);

    foreach (vt[i]) begin
      if (vt[i].rst) do_reset();
      step(vt[i].vld, vt[i].w, vt[i].en, vt[i].clr);
      chk($sformatf("vec%0d tr_data", i),   64'(tr_data),   64'(vt[i].e_data));
      chk($sformatf("vec%0d tr_active", i), 64'(tr_active), 64'(vt[i].e_act));
      chk($sformatf("vec%0d tr_clk", i),    64'(tr_clk),    64'(vt[i].e_clk));
      chk($sformatf("vec%0d fifo_full", i), 64'(fifo_full), 64'(vt[i].e_full));
      chk($sformatf("vec%0d ovf_count", i), 64'(ovf_count), 64'(vt[i].e_ovf));
    end

    // Back-to-back: four words give eight contiguous active cycles.
    do_reset();
    first_act = -1; last_act = -1; n_act = 0;
    for (int c = 0; c < 16; c++) begin
      step(c < 4, wk(20 + c), 1, 0);
      if (tr_active) begin
        if (first_act < 0) first_act = c;
        last_act = c;
        n_act++;
      end
    end
    chk("b2b active cycles", 64'(n_act), 64'd8);
    chk("b2b contiguous", 64'(last_act - first_act + 1), 64'd8);
    chk("b2b ovf_count", 64'(ovf_count), 64'd0);

    // Full FIFO with a same-cycle pop and push: nothing dropped, order kept.
    do_reset();
    for (int k = 1; k <= 4; k++) step(1, wk(k), 0, 0);
    chk("full before pop+push", 64'(fifo_full), 64'd1);
    step(1, wk(5), 1, 0);
    chk("pop+push ovf_count", 64'(ovf_count), 64'd0);
    chk("pop+push still full", 64'(fifo_full), 64'd1);
    got.delete();
    for (int c = 0; c < 14; c++) begin
      step(0, '0, 1, 0);
      if (tr_active) got.push_back(tr_data);
    end
    exp_sl.delete();
    for (int k = 1; k <= 5; k++) begin
      exp_sl.push_back(18'(32'h0A00 + k));
      exp_sl.push_back(18'(32'h0B00 + k));
    end
    chk("pop+push slice count", 64'(got.size()), 64'(exp_sl.size()));
    foreach (exp_sl[i])
      if (i < got.size()) chk($sformatf("pop+push slice%0d", i), 64'(got[i]), 64'(exp_sl[i]));

    // Disable mid-word: the word completes, the queued one waits.
    step(1, wk(30), 1, 0);
    step(1, wk(31), 1, 0);
    step(0, '0, 0, 0);
    chk("middis hi slice", 64'(tr_data), 64'(18'(32'h0A00 + 30)));
    step(0, '0, 0, 0);
    chk("middis lo slice", 64'(tr_data), 64'(18'(32'h0B00 + 30)));
    chk("middis lo active", 64'(tr_active), 64'd1);
    step(0, '0, 0, 0);
    chk("middis idle after", 64'(tr_active), 64'd0);
    for (int c = 0; c < 4; c++) step(0, '0, 1, 0);

    // Saturation and clear.
    do_reset();
    for (int k = 1; k <= 4; k++) step(1, wk(k), 0, 0);
    for (int c = 0; c < 300; c++) step(1, 36'({$urandom(), $urandom()}), 0, 0);
    chk("ovf saturated", 64'(ovf_count), 64'd255);
    step(1, wk(9), 0, 1);
    chk("ovf clr with drop", 64'(ovf_count), 64'd1);
    step(0, '0, 0, 1);
    chk("ovf clr alone", 64'(ovf_count), 64'd0);

    // Asynchronous reset during the first slice.
    do_reset();
    step(1, 36'h9_ABCD_1234, 1, 0);
    step(0, '0, 1, 0);
    step(0, '0, 1, 0);
    chk("pre-reset active", 64'(tr_active), 64'd1);
    #2;
    jrst_n = 0;
    #1;
    chk("async rst tr_data",   64'(tr_data),   64'd0);
    chk("async rst tr_active", 64'(tr_active), 64'd0);
    chk("async rst tr_clk",    64'(tr_clk),    64'd0);
    chk("async rst fifo_full", 64'(fifo_full), 64'd0);
    chk("async rst ovf_count", 64'(ovf_count), 64'd0);
    model_reset();
    jrst_n = 1;
    step(1, 36'h1_2345_6789, 1, 0);
    for (int c = 0; c < 4; c++) step(0, '0, 1, 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++)
      step($urandom_range(0, 9) < 6, 36'({$urandom(), $urandom()}),
           $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
